// File: rtl/burst_mem_responder.sv
// Single-port, byte-addressed burst memory responder (1/4/8/16-beat bursts, big-endian words).
// Optional feature: define MEM_BOUNDS_CHECK_EN to flag and suppress out-of-range beats.
module burst_mem_responder #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 1048576,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h80020000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            access_size,
    input  logic                  rw,
    input  logic                  enable,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  addr_err
);

    localparam int MEM_AW = $clog2(DEPTH);
    localparam int BYTES  = DATA_WIDTH / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [3:0]            r_count;
    logic [3:0]            w_next_count;
    logic [3:0]            w_len_m1;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_rw;
    logic [ADDR_WIDTH-1:0] w_beat_addr;
    logic                  w_beat_rw;
    logic                  w_beat_en;
    logic                  w_access;
    logic [ADDR_WIDTH-1:0] w_offset;
    logic [MEM_AW-1:0]     w_index;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [DATA_WIDTH-1:0] w_read_word;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic [7:0]            r_mem [DEPTH];

    // Remaining beats after beat 0, i.e. burst length minus one.
    always_comb begin
        unique case (access_size)
            2'b00:   w_len_m1 = 4'd0;
            2'b01:   w_len_m1 = 4'd3;
            2'b10:   w_len_m1 = 4'd7;
            default: w_len_m1 = 4'd15;
        endcase
    end

    // NOTE: every output of this block gets a default before the case, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        w_beat_en    = 1'b0;
        w_beat_addr  = r_addr;
        w_beat_rw    = r_rw;
        case (r_state)
            IDLE: begin
                w_beat_addr = address & ~ADDR_WIDTH'(3);
                w_beat_rw   = rw;
                if (enable) begin
                    w_beat_en    = 1'b1;
                    w_next_count = w_len_m1;
                    if (w_len_m1 != 4'd0) begin
                        w_next_state = BURST;
                    end
                end
            end
            BURST: begin
                w_beat_en    = 1'b1;
                w_next_count = r_count - 4'd1;
                if (r_count == 4'd1) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_offset = w_beat_addr - START_ADDR;
    assign w_index  = MEM_AW'(w_offset);

    always_comb begin
        w_rdata = '0;
        for (int b = 0; b < BYTES; b++) begin
            w_rdata[DATA_WIDTH-1-8*b -: 8] = r_mem[w_index + MEM_AW'(b)];
        end
    end

`ifdef MEM_BOUNDS_CHECK_EN
    localparam logic [DATA_WIDTH-1:0] OOB_DATA = DATA_WIDTH'(32'hDEADBEEF);

    logic w_in_range;
    logic r_addr_err;

    // Addresses below START_ADDR wrap to huge offsets, so one compare covers both sides.
    assign w_in_range  = (w_offset < ADDR_WIDTH'(DEPTH));
    assign w_access    = w_beat_en & w_in_range;
    assign w_read_word = w_in_range ? w_rdata : OOB_DATA;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr_err <= 1'b0;
        end else if (w_beat_en && !w_in_range) begin
            r_addr_err <= 1'b1;
        end
    end

    assign addr_err = r_addr_err;
`else
    assign w_access    = w_beat_en;
    assign w_read_word = w_rdata;
    assign addr_err    = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= 4'd0;
            r_addr     <= '0;
            r_rw       <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
            if (w_beat_en) begin
                r_addr <= w_beat_addr + ADDR_WIDTH'(4);
                r_rw   <= w_beat_rw;
                if (w_beat_rw) begin
                    r_data_out <= w_read_word;
                end
            end
        end
    end

    // NOTE: storage has no reset; a reset edge only blocks the write that would land on it.
    always_ff @(posedge clock) begin
        if (!reset && w_access && !w_beat_rw) begin
            for (int b = 0; b < BYTES; b++) begin
                r_mem[w_index + MEM_AW'(b)] <= data_in[DATA_WIDTH-1-8*b -: 8];
            end
        end
    end

    assign busy     = (r_state == BURST);
    assign data_out = r_data_out;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Self-checking bench for burst_mem_responder: queue-based beat model plus directed literal checks.
// Builds with or without MEM_BOUNDS_CHECK_EN.
module tb_burst_mem_responder;

    localparam int          DW    = 32;
    localparam int          AW    = 32;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] START = 32'h80020000;

    logic          clock       = 1'b0;
    logic          reset       = 1'b1;
    logic          enable      = 1'b0;
    logic          rw          = 1'b0;
    logic [AW-1:0] address     = '0;
    logic [DW-1:0] data_in     = '0;
    logic [1:0]    access_size = 2'b00;
    logic          busy;
    logic [DW-1:0] data_out;
    logic          addr_err;

    always #5 clock = ~clock;

    burst_mem_responder #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH),
        .START_ADDR(START)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .address    (address),
        .data_in    (data_in),
        .access_size(access_size),
        .rw         (rw),
        .enable     (enable),
        .busy       (busy),
        .data_out   (data_out),
        .addr_err   (addr_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int beats(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return 16;
        endcase
    endfunction

    // Model: a burst is a queue of beat addresses, one popped per accepted edge.
    logic [7:0]  m_mem [logic [31:0]];
    logic [31:0] pend[$];
    logic        m_rw     = 1'b0;
    logic [31:0] exp_dout = '0;
    logic        exp_busy = 1'b0;
    logic        exp_err  = 1'b0;
    logic        cmp_en   = 1'b0;

    task automatic model_beat(input logic [31:0] a);
        logic [31:0] off;
        off = a - START;
`ifdef MEM_BOUNDS_CHECK_EN
        if (off >= DEPTH) begin
            exp_err = 1'b1;
            if (m_rw) exp_dout = 32'hDEADBEEF;
            return;
        end
`endif
        off = off % DEPTH;
        if (m_rw) begin
            exp_dout = {m_mem[off], m_mem[(off+1)%DEPTH], m_mem[(off+2)%DEPTH], m_mem[(off+3)%DEPTH]};
        end else begin
            for (int b = 0; b < 4; b++) m_mem[(off + b) % DEPTH] = data_in[31-8*b -: 8];
        end
    endtask

    always @(posedge clock) begin
        if (reset) begin
            pend.delete();
            exp_dout = '0;
            exp_err  = 1'b0;
        end else begin
            if (pend.size() == 0 && enable) begin
                m_rw = rw;
                for (int k = 0; k < beats(access_size); k++) begin
                    pend.push_back((address & ~32'h3) + 32'(4 * k));
                end
            end
            if (pend.size() != 0) model_beat(pend.pop_front());
        end
        exp_busy = (pend.size() != 0);
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            check("cyc_busy", {31'd0, busy}, {31'd0, exp_busy});
            check("cyc_data_out", data_out, exp_dout);
            check("cyc_addr_err", {31'd0, addr_err}, {31'd0, exp_err});
        end
    end

    logic [31:0] wdata[16];
    logic [31:0] cap[16];
    int          busy_cnt;

    // Called at a negedge; returns at the negedge after the final beat edge.
    task automatic burst(input logic [31:0] a, input logic [1:0] sz, input logic r);
        int n;
        n           = beats(sz);
        address     = a;
        access_size = sz;
        rw          = r;
        enable      = 1'b1;
        data_in     = wdata[0];
        @(negedge clock);
        enable   = 1'b0;
        cap[0]   = data_out;
        busy_cnt = int'(busy);
        for (int k = 1; k < n; k++) begin
            data_in = wdata[k];
            @(negedge clock);
            cap[k]   = data_out;
            busy_cnt += int'(busy);
        end
    endtask

    initial begin
        repeat (2) @(negedge clock);
        reset  = 1'b0;
        cmp_en = 1'b1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_addr_err", {31'd0, addr_err}, 32'd0);

        // Single write then single read.
        wdata[0] = 32'h27BDFFF8;
        burst(32'h80020000, 2'b00, 1'b0);
        check("single_wr_busy", busy_cnt, 0);
        burst(32'h80020000, 2'b00, 1'b1);
        check("single_rd_busy", busy_cnt, 0);
        check("single_rd_data", cap[0], 32'h27BDFFF8);

        // 4-beat write and read back.
        for (int k = 0; k < 4; k++) wdata[k] = 32'h11111111 * (k + 1);
        burst(32'h80020010, 2'b01, 1'b0);
        check("b4_wr_busy", busy_cnt, 3);
        burst(32'h80020010, 2'b01, 1'b1);
        check("b4_rd_busy", busy_cnt, 3);
        check("b4_rd0", cap[0], 32'h11111111);
        check("b4_rd1", cap[1], 32'h22222222);
        check("b4_rd2", cap[2], 32'h33333333);
        check("b4_rd3", cap[3], 32'h44444444);

        // Low address bits are ignored.
        burst(32'h80020013, 2'b00, 1'b1);
        check("unaligned_rd", cap[0], 32'h11111111);

        // 16-beat read with enable held and address changed while busy.
        for (int k = 0; k < 16; k++) wdata[k] = 32'hC0DE0000 + k;
        burst(32'h80020040, 2'b11, 1'b0);
        check("b16_wr_busy", busy_cnt, 15);
        address     = 32'h80020040;
        access_size = 2'b11;
        rw          = 1'b1;
        enable      = 1'b1;
        @(negedge clock);
        address     = 32'h80020010;
        access_size = 2'b00;
        cap[0]      = data_out;
        busy_cnt    = int'(busy);
        for (int k = 1; k < 16; k++) begin
            @(negedge clock);
            cap[k]   = data_out;
            busy_cnt += int'(busy);
        end
        check("b16_rd_busy", busy_cnt, 15);
        check("b16_rd_first", cap[0], 32'hC0DE0000);
        check("b16_rd_last", cap[15], 32'hC0DE000F);
        @(negedge clock);
        enable = 1'b0;
        check("held_req_data", data_out, 32'h11111111);
        check("held_req_busy", {31'd0, busy}, 32'd0);

        // Reset during the third busy cycle of an 8-beat write.
        for (int k = 0; k < 8; k++) wdata[k] = 32'hA0000000 + k;
        burst(32'h80020100, 2'b10, 1'b0);
        address     = 32'h80020100;
        access_size = 2'b10;
        rw          = 1'b0;
        enable      = 1'b1;
        data_in     = 32'hB0000000;
        @(negedge clock);
        enable  = 1'b0;
        data_in = 32'hB0000001;
        @(negedge clock);
        data_in = 32'hB0000002;
        @(negedge clock);
        reset   = 1'b1;
        data_in = 32'hB0000003;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_data_out", data_out, 32'd0);
        burst(32'h80020100, 2'b10, 1'b1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("abort_rd%0d", k), cap[k], (k < 3) ? 32'hB0000000 + k : 32'hA0000000 + k);
        end

        // Big-endian byte layout in storage.
        wdata[0] = 32'hAABBCCDD;
        burst(32'h80020004, 2'b00, 1'b0);
        check("be_byte4", {24'd0, dut.r_mem[4]}, 32'hAA);
        check("be_byte5", {24'd0, dut.r_mem[5]}, 32'hBB);
        check("be_byte6", {24'd0, dut.r_mem[6]}, 32'hCC);
        check("be_byte7", {24'd0, dut.r_mem[7]}, 32'hDD);
        burst(32'h80020004, 2'b00, 1'b1);
        check("be_rd", cap[0], 32'hAABBCCDD);

`ifdef MEM_BOUNDS_CHECK_EN
        burst(32'h80000000, 2'b00, 1'b1);
        check("oob_rd", cap[0], 32'hDEADBEEF);
        check("oob_err", {31'd0, addr_err}, 32'd1);
        burst(32'h80020000, 2'b00, 1'b1);
        check("oob_err_sticky", {31'd0, addr_err}, 32'd1);
        check("oob_then_inrange", cap[0], 32'h27BDFFF8);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("oob_err_cleared", {31'd0, addr_err}, 32'd0);
`else
        burst(START + DEPTH, 2'b00, 1'b1);
        check("wrap_rd", cap[0], 32'h27BDFFF8);
        check("wrap_err", {31'd0, addr_err}, 32'd0);
`endif

        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
